// File: rtl/button_conditioner.sv
// button_conditioner
//   Cleans up the raw front-panel push buttons of the Nim game. Every channel
//   goes through a 2-FF synchronizer, a counter-based debouncer and a
//   single-cycle press-pulse generator. Channels selected by REPEAT_MASK also
//   auto-repeat while held: first repeat REPEAT_DELAY cycles after the press
//   pulse, then one pulse every REPEAT_PERIOD cycles.
//
// Ports
//   clk        in            system clock
//   reset      in            asynchronous, active-high reset
//   btn_raw    in  [N_BTN]   raw bouncing button inputs, 1 = pressed
//   btn_level  out [N_BTN]   debounced stable level per channel
//   btn_pulse  out [N_BTN]   one-clock press event per channel (incl. repeats)
module button_conditioner #(
  parameter int unsigned       N_BTN           = 10,
  parameter int unsigned       DEBOUNCE_CYCLES = 1000000,
  parameter logic [N_BTN-1:0]  REPEAT_MASK     = N_BTN'(10'b0000001111),
  parameter int unsigned       REPEAT_DELAY    = 50000000,
  parameter int unsigned       REPEAT_PERIOD   = 20000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_pulse
);

  localparam int unsigned DB_W   = ($clog2(DEBOUNCE_CYCLES) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RP_W   = ($clog2(RP_MAX) < 1) ? 1 : $clog2(RP_MAX);

  localparam logic [DB_W-1:0] DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RP_W-1:0] DELAY_LAST  = RP_W'(REPEAT_DELAY - 1);
  localparam logic [RP_W-1:0] PERIOD_LAST = RP_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_REPEAT
  } rep_state_t;

  logic [N_BTN-1:0] r_sync1;
  logic [N_BTN-1:0] r_sync2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan

    // ---------------- debouncer ----------------
    logic [DB_W-1:0] r_db_cnt;
    logic            r_level;
    logic            w_db_hit;
    logic            w_level_nxt;
    logic            w_rise;

    always_comb begin
      w_db_hit    = (r_sync2[i] != r_level) && (r_db_cnt == DB_LAST);
      w_level_nxt = w_db_hit ? ~r_level : r_level;
      w_rise      = w_db_hit && !r_level;
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_db_cnt <= '0;
        r_level  <= 1'b0;
      end else if (r_sync2[i] == r_level) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_LAST) begin
        r_db_cnt <= '0;
        r_level  <= ~r_level;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end

    // ---------------- press / repeat FSM ----------------
    // The FSM looks at the level being loaded on this edge (w_level_nxt) so
    // the press pulse lines up with the first cycle btn_level reads 1, and a
    // release on a repeat edge suppresses that repeat pulse.
    rep_state_t      r_state;
    rep_state_t      w_state_nxt;
    logic [RP_W-1:0] r_rep_cnt;
    logic [RP_W-1:0] w_rep_cnt_nxt;
    logic            r_pulse;
    logic            w_pulse_nxt;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_state   <= ST_IDLE;
        r_rep_cnt <= '0;
        r_pulse   <= 1'b0;
      end else begin
        r_state   <= w_state_nxt;
        r_rep_cnt <= w_rep_cnt_nxt;
        r_pulse   <= w_pulse_nxt;
      end
    end

    always_comb begin
      w_state_nxt   = r_state;
      w_rep_cnt_nxt = r_rep_cnt;
      if (!w_level_nxt) begin
        w_state_nxt   = ST_IDLE;
        w_rep_cnt_nxt = '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            w_rep_cnt_nxt = '0;
            if (w_rise && REPEAT_MASK[i]) begin
              w_state_nxt = ST_DELAY;
            end
          end
          ST_DELAY: begin
            if (r_rep_cnt == DELAY_LAST) begin
              w_state_nxt   = ST_REPEAT;
              w_rep_cnt_nxt = '0;
            end else begin
              w_rep_cnt_nxt = r_rep_cnt + 1'b1;
            end
          end
          ST_REPEAT: begin
            if (r_rep_cnt == PERIOD_LAST) begin
              w_rep_cnt_nxt = '0;
            end else begin
              w_rep_cnt_nxt = r_rep_cnt + 1'b1;
            end
          end
          default: begin
            w_state_nxt   = ST_IDLE;
            w_rep_cnt_nxt = '0;
          end
        endcase
      end
    end

    always_comb begin
      w_pulse_nxt = 1'b0;
      if (w_level_nxt) begin
        case (r_state)
          ST_IDLE:   w_pulse_nxt = w_rise;
          ST_DELAY:  w_pulse_nxt = (r_rep_cnt == DELAY_LAST);
          ST_REPEAT: w_pulse_nxt = (r_rep_cnt == PERIOD_LAST);
          default:   w_pulse_nxt = 1'b0;
        endcase
      end
    end

    assign btn_level[i] = r_level;
    assign btn_pulse[i] = r_pulse;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner
//   Directed bench for button_conditioner with DEBOUNCE_CYCLES=4,
//   REPEAT_DELAY=10, REPEAT_PERIOD=3, N_BTN=10, REPEAT_MASK=10'b0000001111.
//   A behavioural model (raw-sample history window + edges-since-press
//   arithmetic) is compared against the DUT on every falling clock edge;
//   directed scenarios add hand-computed literal checks.
module tb_button_conditioner;

  localparam int N   = 10;
  localparam int DEB = 4;
  localparam int RD  = 10;
  localparam int RP  = 3;
  localparam logic [N-1:0] MASK = 10'b0000001111;

  logic         clk;
  logic         reset;
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_pulse;

  int n_cmp = 0;
  int n_bad = 0;

  button_conditioner #(
    .N_BTN          (N),
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_MASK    (MASK),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_raw  (btn_raw),
    .btn_level(btn_level),
    .btn_pulse(btn_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int unsigned act, input int unsigned req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, act, req);
    end
  endtask

  // ---------------- behavioural model ----------------
  // rawq holds the raw samples of the last DEB+2 edges (oldest first). The
  // level changes when the DEB samples that have reached the synchronizer
  // output all differ from the current level.
  logic [N-1:0] rawq[$];
  logic [N-1:0] m_lvl;
  logic [N-1:0] m_pulse;
  int           m_since[N];

  task automatic model_reset();
    rawq.delete();
    for (int j = 0; j < DEB + 2; j++) rawq.push_back('0);
    m_lvl   = '0;
    m_pulse = '0;
    for (int c = 0; c < N; c++) m_since[c] = 0;
  endtask

  task automatic model_edge(input logic [N-1:0] raw);
    logic diff;
    logic rise;
    rawq.push_back(raw);
    void'(rawq.pop_front());
    for (int c = 0; c < N; c++) begin
      diff = 1'b1;
      for (int j = 0; j < DEB; j++)
        if (rawq[j][c] == m_lvl[c]) diff = 1'b0;
      rise = diff && !m_lvl[c];
      if (diff) m_lvl[c] = ~m_lvl[c];
      if (rise) m_since[c] = 0;
      else if (m_lvl[c]) m_since[c]++;
      m_pulse[c] = m_lvl[c] && (rise ||
                   (MASK[c] && m_since[c] >= RD && ((m_since[c] - RD) % RP) == 0));
    end
  endtask

  initial model_reset();

  // Inputs change only #1 after a rising edge, so btn_raw at a falling edge
  // is exactly what the next rising edge samples.
  always @(negedge clk) begin
    if (reset) model_reset();
    chk("model level", btn_level, m_lvl);
    chk("model pulse", btn_pulse, m_pulse);
    if (!reset) model_edge(btn_raw);
  end

  // ---------------- directed stimulus ----------------
  int offs[$];
  logic lvl_tr[0:63];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  // raw[ch] is expected to have just been set; records the edge offsets at
  // which channel ch pulses and releases raw[ch] after edge 'hold'.
  task automatic run_record(input int ch, input int total, input int hold);
    offs.delete();
    for (int o = 1; o <= total; o++) begin
      tick();
      lvl_tr[o] = btn_level[ch];
      if (btn_pulse[ch]) offs.push_back(o);
      if (o == hold) btn_raw[ch] = 1'b0;
    end
  endtask

  task automatic chk_offs(input string nm, input int req[$]);
    chk({nm, " count"}, offs.size(), req.size());
    for (int k = 0; k < req.size() && k < offs.size(); k++)
      chk({nm, " offset"}, offs[k], req[k]);
  endtask

  int exp_single[$];
  int exp_rep0[$];
  int exp_rep2[$];
  int bounce_pulses;

  initial begin
    exp_single = '{6};
    exp_rep0   = '{6, 16, 19, 22, 25, 28, 31, 34, 37, 40, 43};
    exp_rep2   = '{6, 16, 19, 22, 25, 28};

    reset   = 1'b1;
    btn_raw = '0;
    ticks(3);
    chk("reset level", btn_level, 0);
    chk("reset pulse", btn_pulse, 0);
    reset = 1'b0;
    ticks(10);
    chk("idle level", btn_level, 0);
    chk("idle pulse", btn_pulse, 0);

    // clean press on channel 5, released after 20 edges
    btn_raw[5] = 1'b1;
    run_record(5, 30, 20);
    chk_offs("ch5 press", exp_single);
    chk("ch5 lvl@5", lvl_tr[5], 0);
    chk("ch5 lvl@6", lvl_tr[6], 1);
    chk("ch5 lvl@25", lvl_tr[25], 1);
    chk("ch5 lvl@26", lvl_tr[26], 0);

    // bounce on channel 6, then stable
    bounce_pulses = 0;
    for (int b = 0; b < 4; b++) begin
      btn_raw[6] = (b % 2 == 0);
      for (int k = 0; k < 2; k++) begin
        tick();
        if (btn_pulse[6] || btn_level[6]) bounce_pulses++;
      end
    end
    chk("ch6 bounce quiet", bounce_pulses, 0);
    btn_raw[6] = 1'b1;
    run_record(6, 30, 15);
    chk_offs("ch6 press", exp_single);
    chk("ch6 lvl@5", lvl_tr[5], 0);
    chk("ch6 lvl@6", lvl_tr[6], 1);

    // auto-repeat on channel 0, held 40 edges; release coincides with a
    // would-be repeat at offset 46
    btn_raw[0] = 1'b1;
    run_record(0, 55, 40);
    chk_offs("ch0 repeat", exp_rep0);
    chk("ch0 lvl@45", lvl_tr[45], 1);
    chk("ch0 lvl@46", lvl_tr[46], 0);

    // no-repeat channel 8
    btn_raw[8] = 1'b1;
    run_record(8, 55, 40);
    chk_offs("ch8 norepeat", exp_single);

    // simultaneous press on channels 1 (repeat) and 7 (no repeat)
    btn_raw[1] = 1'b1;
    btn_raw[7] = 1'b1;
    ticks(5);
    chk("sim pulse@5", {btn_pulse[7], btn_pulse[1]}, 2'b00);
    tick();
    chk("sim pulse@6", {btn_pulse[7], btn_pulse[1]}, 2'b11);
    chk("sim level@6", {btn_level[7], btn_level[1]}, 2'b11);
    ticks(10);
    chk("sim pulse@16", {btn_pulse[7], btn_pulse[1]}, 2'b01);
    btn_raw[1] = 1'b0;
    btn_raw[7] = 1'b0;
    ticks(12);

    // reset during DELAY on channel 2, button held through reset
    btn_raw[2] = 1'b1;
    ticks(8);
    chk("ch2 pre-reset lvl", btn_level[2], 1);
    reset = 1'b1;
    #1;
    chk("async reset level", btn_level, 0);
    chk("async reset pulse", btn_pulse, 0);
    ticks(3);
    reset = 1'b0;
    run_record(2, 30, 24);
    chk_offs("ch2 after reset", exp_rep2);
    ticks(10);
    chk("final level", btn_level, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t actual=running required=finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
